// File: rtl/plab4_net_router_input_ctrl_wh_pkg.sv
// Shared encodings and defaults for the plab4 ring-router input controllers.
package plab4_net_RouterPkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int ROUTE_PASS     = 0;
  localparam int ROUTE_SHORTEST = 1;

  localparam int DEF_BWD_PORT  = 0;
  localparam int DEF_TERM_PORT = 1;
  localparam int DEF_FWD_PORT  = 2;

endpackage

// File: rtl/plab4_net_router_input_ctrl_wh_route.sv
// Combinational route function: destination id to a one-hot output-port request.
module plab4_net_RouteCompute
  import plab4_net_RouterPkg::*;
#(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_ports   = 3,
  parameter int p_term_port   = DEF_TERM_PORT,
  parameter int p_fwd_port    = DEF_FWD_PORT,
  parameter int p_bwd_port    = DEF_BWD_PORT,
  parameter int p_route_mode  = ROUTE_PASS,
  localparam int c_dest_nbits = $clog2(p_num_routers)
) (
  input  logic [c_dest_nbits-1:0] dest,
  output logic [p_num_ports-1:0]  reqs
);

  localparam logic [c_dest_nbits-1:0] c_id   = c_dest_nbits'(p_router_id);
  localparam logic [c_dest_nbits:0]   c_n    = (c_dest_nbits+1)'(p_num_routers);
  localparam logic [c_dest_nbits:0]   c_half = (c_dest_nbits+1)'(p_num_routers / 2);

  logic [c_dest_nbits:0] diff;
  logic [c_dest_nbits:0] fwd;

  // Adding N before subtracting keeps the difference non-negative; one
  // conditional subtract then yields (dest - id) mod N for any ring size.
  always_comb begin
    diff = {1'b0, dest} + c_n - {1'b0, c_id};
    fwd  = (diff >= c_n) ? (diff - c_n) : diff;
    reqs = '0;
    if (dest == c_id)
      reqs[p_term_port] = 1'b1;
    else if ((p_route_mode == ROUTE_SHORTEST) && (fwd <= c_half))
      reqs[p_fwd_port] = 1'b1;
    else
      reqs[p_bwd_port] = 1'b1;
  end

endmodule

// File: rtl/plab4_net_router_input_ctrl_wh.sv
// Wormhole input-port controller: routes the head flit and holds that output
// request until the tail flit transfers.
module plab4_net_router_input_ctrl_wh
  import plab4_net_RouterPkg::*;
#(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_ports   = 3,
  parameter int p_term_port   = DEF_TERM_PORT,
  parameter int p_fwd_port    = DEF_FWD_PORT,
  parameter int p_bwd_port    = DEF_BWD_PORT,
  parameter int p_route_mode  = ROUTE_PASS,
  parameter int p_max_flits   = 16,
  localparam int c_dest_nbits = $clog2(p_num_routers),
  localparam int c_cnt_nbits  = $clog2(p_max_flits + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  input  logic [c_dest_nbits-1:0] dest,
  input  logic                    head,
  input  logic                    tail,
  input  logic                    in_val,
  output logic                    in_rdy,
  output logic [p_num_ports-1:0]  reqs,
  input  logic [p_num_ports-1:0]  grants,
  output logic                    pkt_active,
  output logic                    pkt_domain,
  output logic [c_cnt_nbits-1:0]  flit_cnt,
  output logic                    err
);

  localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] c_cnt_max  = c_cnt_nbits'(p_max_flits);
  localparam logic [c_cnt_nbits-1:0] c_cnt_last = c_cnt_nbits'(p_max_flits - 1);

  function automatic logic [c_cnt_nbits-1:0] sat_inc(input logic [c_cnt_nbits-1:0] v);
    return (v == c_cnt_max) ? v : (v + c_cnt_one);
  endfunction

  state_t                   state_p1;
  state_t                   state_n;
  logic [p_num_ports-1:0]   lock_reqs_p1;
  logic                     pkt_domain_p1;
  logic [c_cnt_nbits-1:0]   flit_cnt_p1;
  logic                     err_p1;
  logic [p_num_ports-1:0]   route_reqs;
  logic                     xfer;

  plab4_net_RouteCompute #(
    .p_router_id   (p_router_id),
    .p_num_routers (p_num_routers),
    .p_num_ports   (p_num_ports),
    .p_term_port   (p_term_port),
    .p_fwd_port    (p_fwd_port),
    .p_bwd_port    (p_bwd_port),
    .p_route_mode  (p_route_mode)
  ) u_route (
    .dest (dest),
    .reqs (route_reqs)
  );

  // Orphan body flits in IDLE are accepted unconditionally so they drain
  // from the input queue instead of blocking it forever.
  always_comb begin
    reqs    = '0;
    in_rdy  = 1'b0;
    state_n = state_p1;
    case (state_p1)
      IDLE: begin
        if (in_val) begin
          if (head) begin
            reqs   = route_reqs;
            in_rdy = |(route_reqs & grants);
            if (in_rdy && !tail)
              state_n = LOCKED;
          end else begin
            in_rdy = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (in_val) begin
          reqs   = lock_reqs_p1;
          in_rdy = |(lock_reqs_p1 & grants);
          if (in_rdy && tail)
            state_n = IDLE;
        end
      end
    endcase
  end

  assign xfer = in_val & in_rdy;

  // State, lock, count and error register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1      <= IDLE;
      lock_reqs_p1  <= '0;
      pkt_domain_p1 <= 1'b0;
      flit_cnt_p1   <= '0;
      err_p1        <= 1'b0;
    end else begin
      state_p1 <= state_n;
      if (xfer) begin
        case (state_p1)
          IDLE: begin
            if (!head) begin
              err_p1 <= 1'b1;
            end else if (!tail) begin
              lock_reqs_p1  <= route_reqs;
              pkt_domain_p1 <= domain;
              flit_cnt_p1   <= c_cnt_one;
            end
          end
          LOCKED: begin
            if (head)
              err_p1 <= 1'b1;
            if (tail) begin
              flit_cnt_p1 <= '0;
            end else begin
              flit_cnt_p1 <= sat_inc(flit_cnt_p1);
              if (flit_cnt_p1 == c_cnt_last)
                err_p1 <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign pkt_active = (state_p1 == LOCKED);
  assign pkt_domain = pkt_domain_p1;
  assign flit_cnt   = flit_cnt_p1;
  assign err        = err_p1;

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_wh.sv
// Directed bench for the wormhole input controller: pass-through instance
// (id 2) and shortest-direction instance (id 1) on an 8-router ring.
module tb_plab4_net_router_input_ctrl_wh;

  logic       clk = 1'b0;
  logic       reset;

  logic       domain;
  logic [2:0] dest;
  logic       head, tail, in_val;
  logic       in_rdy;
  logic [2:0] reqs, grants;
  logic       pkt_active, pkt_domain, err;
  logic [4:0] flit_cnt;

  logic       d0_domain;
  logic [2:0] d0_dest;
  logic       d0_head, d0_tail, d0_in_val;
  logic       d0_in_rdy;
  logic [2:0] d0_reqs, d0_grants;
  logic       d0_pkt_active, d0_pkt_domain, d0_err;
  logic [4:0] d0_flit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plab4_net_router_input_ctrl_wh #(
    .p_router_id(1), .p_num_routers(8), .p_num_ports(3), .p_term_port(1),
    .p_fwd_port(2), .p_bwd_port(0), .p_route_mode(1), .p_max_flits(16)
  ) u_dut (
    .clk(clk), .reset(reset), .domain(domain), .dest(dest), .head(head),
    .tail(tail), .in_val(in_val), .in_rdy(in_rdy), .reqs(reqs),
    .grants(grants), .pkt_active(pkt_active), .pkt_domain(pkt_domain),
    .flit_cnt(flit_cnt), .err(err)
  );

  plab4_net_router_input_ctrl_wh #(
    .p_router_id(2), .p_num_routers(8), .p_num_ports(3), .p_term_port(1),
    .p_fwd_port(2), .p_bwd_port(0), .p_route_mode(0), .p_max_flits(16)
  ) u_dut0 (
    .clk(clk), .reset(reset), .domain(d0_domain), .dest(d0_dest),
    .head(d0_head), .tail(d0_tail), .in_val(d0_in_val), .in_rdy(d0_in_rdy),
    .reqs(d0_reqs), .grants(d0_grants), .pkt_active(d0_pkt_active),
    .pkt_domain(d0_pkt_domain), .flit_cnt(d0_flit_cnt), .err(d0_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flit(input logic [2:0] d, input logic h, input logic t,
                      input logic dom, input logic [2:0] g);
    dest = d; head = h; tail = t; domain = dom; grants = g; in_val = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    in_val = 1'b0; d0_in_val = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_val = 1'b0; head = 1'b0; tail = 1'b0; dest = 3'd0; domain = 1'b0; grants = 3'b000;
    d0_in_val = 1'b0; d0_head = 1'b0; d0_tail = 1'b0; d0_dest = 3'd0;
    d0_domain = 1'b0; d0_grants = 3'b000;
    reset = 1'b1;
    step();
    step();
    checks++; if (reqs !== 3'b000) begin errors++; $display("FAIL reset_reqs: got %b want 000", reqs); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL reset_pkt_active: got %b want 0", pkt_active); end
    checks++; if (pkt_domain !== 1'b0) begin errors++; $display("FAIL reset_pkt_domain: got %b want 0", pkt_domain); end
    checks++; if (flit_cnt !== 5'd0) begin errors++; $display("FAIL reset_flit_cnt: got %0d want 0", flit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    d0_dest = 3'd2; d0_head = 1'b1; d0_tail = 1'b1; d0_grants = 3'b010; d0_in_val = 1'b1;
    #1;
    checks++; if (d0_reqs !== 3'b010) begin errors++; $display("FAIL m0_local_reqs: got %b want 010", d0_reqs); end
    checks++; if (d0_in_rdy !== 1'b1) begin errors++; $display("FAIL m0_local_in_rdy: got %b want 1", d0_in_rdy); end
    step();
    checks++; if (d0_pkt_active !== 1'b0) begin errors++; $display("FAIL m0_single_idle: got %b want 0", d0_pkt_active); end
    checks++; if (d0_flit_cnt !== 5'd0) begin errors++; $display("FAIL m0_single_cnt: got %0d want 0", d0_flit_cnt); end
    d0_dest = 3'd5;
    #1;
    checks++; if (d0_reqs !== 3'b001) begin errors++; $display("FAIL m0_remote_reqs: got %b want 001", d0_reqs); end
    checks++; if (d0_in_rdy !== 1'b0) begin errors++; $display("FAIL m0_remote_in_rdy: got %b want 0", d0_in_rdy); end
    d0_in_val = 1'b0;
    #1;
    checks++; if (d0_reqs !== 3'b000) begin errors++; $display("FAIL m0_noval_reqs: got %b want 000", d0_reqs); end
    step();
  endtask

  task automatic test_route_shortest();
    logic [2:0] dests [4];
    logic [2:0] exp   [4];
    dests[0] = 3'd4; exp[0] = 3'b100;
    dests[1] = 3'd6; exp[1] = 3'b001;
    dests[2] = 3'd5; exp[2] = 3'b100;
    dests[3] = 3'd1; exp[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      flit(dests[i], 1'b1, 1'b1, 1'b0, 3'b000);
      checks++; if (reqs !== exp[i]) begin errors++; $display("FAIL m1_route_dest%0d: got %b want %b", dests[i], reqs, exp[i]); end
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL m1_route_nogrant_rdy%0d: got %b want 0", dests[i], in_rdy); end
    end
    in_val = 1'b0;
    step();
  endtask

  task automatic test_wormhole_stall();
    flit(3'd5, 1'b1, 1'b0, 1'b1, 3'b100);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL wh_head_rdy: got %b want 1", in_rdy); end
    step();
    checks++; if (pkt_active !== 1'b1) begin errors++; $display("FAIL wh_active: got %b want 1", pkt_active); end
    checks++; if (pkt_domain !== 1'b1) begin errors++; $display("FAIL wh_domain: got %b want 1", pkt_domain); end
    checks++; if (flit_cnt !== 5'd1) begin errors++; $display("FAIL wh_cnt1: got %0d want 1", flit_cnt); end
    flit(3'd5, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      checks++; if (reqs !== 3'b100) begin errors++; $display("FAIL wh_stall_reqs%0d: got %b want 100", i, reqs); end
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL wh_stall_rdy%0d: got %b want 0", i, in_rdy); end
      step();
      checks++; if (flit_cnt !== 5'd1) begin errors++; $display("FAIL wh_stall_cnt%0d: got %0d want 1", i, flit_cnt); end
    end
    flit(3'd5, 1'b0, 1'b0, 1'b0, 3'b100);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL wh_resume_rdy: got %b want 1", in_rdy); end
    step();
    checks++; if (flit_cnt !== 5'd2) begin errors++; $display("FAIL wh_cnt2: got %0d want 2", flit_cnt); end
    flit(3'd5, 1'b0, 1'b0, 1'b0, 3'b100);
    step();
    checks++; if (flit_cnt !== 5'd3) begin errors++; $display("FAIL wh_cnt3: got %0d want 3", flit_cnt); end
    flit(3'd5, 1'b0, 1'b1, 1'b0, 3'b100);
    checks++; if (reqs !== 3'b100) begin errors++; $display("FAIL wh_tail_reqs: got %b want 100", reqs); end
    step();
    in_val = 1'b0;
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL wh_tail_idle: got %b want 0", pkt_active); end
    checks++; if (flit_cnt !== 5'd0) begin errors++; $display("FAIL wh_tail_cnt: got %0d want 0", flit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wh_err: got %b want 0", err); end
  endtask

  task automatic test_lock_ignores_dest();
    flit(3'd4, 1'b1, 1'b0, 1'b0, 3'b100);
    step();
    flit(3'd1, 1'b0, 1'b0, 1'b0, 3'b100);
    checks++; if (reqs !== 3'b100) begin errors++; $display("FAIL lock_dest_reqs: got %b want 100", reqs); end
    step();
    flit(3'd4, 1'b1, 1'b0, 1'b0, 3'b100);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL lock_head_rdy: got %b want 1", in_rdy); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL lock_head_err: got %b want 1", err); end
    checks++; if (flit_cnt !== 5'd3) begin errors++; $display("FAIL lock_head_cnt: got %0d want 3", flit_cnt); end
    checks++; if (pkt_active !== 1'b1) begin errors++; $display("FAIL lock_head_active: got %b want 1", pkt_active); end
    flit(3'd4, 1'b0, 1'b1, 1'b0, 3'b100);
    step();
    in_val = 1'b0;
  endtask

  task automatic test_orphan();
    do_reset();
    flit(3'd3, 1'b0, 1'b0, 1'b0, 3'b000);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL orphan_rdy: got %b want 1", in_rdy); end
    checks++; if (reqs !== 3'b000) begin errors++; $display("FAIL orphan_reqs: got %b want 000", reqs); end
    step();
    in_val = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b want 1", err); end
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL orphan_idle: got %b want 0", pkt_active); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err); end
  endtask

  task automatic test_max_flits();
    do_reset();
    flit(3'd4, 1'b1, 1'b0, 1'b0, 3'b100);
    step();
    for (int i = 0; i < 14; i++) begin
      flit(3'd4, 1'b0, 1'b0, 1'b0, 3'b100);
      step();
    end
    checks++; if (flit_cnt !== 5'd15) begin errors++; $display("FAIL max_cnt15: got %0d want 15", flit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err_before: got %b want 0", err); end
    flit(3'd4, 1'b0, 1'b0, 1'b0, 3'b100);
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL max_err: got %b want 1", err); end
    checks++; if (pkt_active !== 1'b1) begin errors++; $display("FAIL max_locked: got %b want 1", pkt_active); end
    checks++; if (flit_cnt !== 5'd16) begin errors++; $display("FAIL max_cnt16: got %0d want 16", flit_cnt); end
    flit(3'd4, 1'b0, 1'b0, 1'b0, 3'b100);
    step();
    checks++; if (flit_cnt !== 5'd16) begin errors++; $display("FAIL max_saturate: got %0d want 16", flit_cnt); end
    flit(3'd4, 1'b0, 1'b1, 1'b0, 3'b100);
    step();
    in_val = 1'b0;
    checks++; if (flit_cnt !== 5'd0) begin errors++; $display("FAIL max_tail_cnt: got %0d want 0", flit_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    flit(3'd4, 1'b1, 1'b0, 1'b1, 3'b100);
    step();
    flit(3'd4, 1'b1, 1'b0, 1'b1, 3'b100);
    step();
    checks++; if (flit_cnt !== 5'd2) begin errors++; $display("FAIL rst_mid_cnt2: got %0d want 2", flit_cnt); end
    flit(3'd4, 1'b0, 1'b0, 1'b1, 3'b100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_val = 1'b0;
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %b want 0", pkt_active); end
    checks++; if (flit_cnt !== 5'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", flit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", err); end
    checks++; if (pkt_domain !== 1'b0) begin errors++; $display("FAIL rst_mid_domain: got %b want 0", pkt_domain); end
    flit(3'd6, 1'b1, 1'b0, 1'b0, 3'b001);
    checks++; if (reqs !== 3'b001) begin errors++; $display("FAIL rst_fresh_reqs: got %b want 001", reqs); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_fresh_rdy: got %b want 1", in_rdy); end
    step();
    checks++; if (flit_cnt !== 5'd1) begin errors++; $display("FAIL rst_fresh_cnt: got %0d want 1", flit_cnt); end
  endtask

  task automatic test_back_to_back();
    flit(3'd6, 1'b0, 1'b1, 1'b0, 3'b001);
    step();
    flit(3'd1, 1'b1, 1'b1, 1'b0, 3'b010);
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", pkt_active); end
    checks++; if (reqs !== 3'b010) begin errors++; $display("FAIL b2b_reqs: got %b want 010", reqs); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: got %b want 1", in_rdy); end
    step();
    in_val = 1'b0;
    checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL b2b_single_idle: got %b want 0", pkt_active); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_route_shortest();
    test_wormhole_stall();
    test_lock_ignores_dest();
    test_orphan();
    test_max_flits();
    test_reset_mid_packet();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
